peak_spectrum_renderer: RTL and testbench

PEAK_SPECTRUM_RENDERER -- requirements
Module: peak_spectrum_renderer

---
 rtl/renderer_pkg.sv | 19 +
 rtl/bin_log2.sv | 38 +++
 rtl/peak_spectrum_renderer.sv | 216 +++++++++++++++++++++
 tb/tb_peak_spectrum_renderer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/renderer_pkg.sv
// -----------------------------------------------------------------------------
// renderer_pkg
// Shared types and constants for the peak spectrum renderer.
//   state_t  : update-handshake states (S_WAIT = nothing pending,
//              S_PEND = shadow holds a spectrum waiting for a blanking edge)
//   C_BLACK, C_GREEN, C_WHITE : 24-bit {R,G,B} pixel colours
// -----------------------------------------------------------------------------
package renderer_pkg;

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_PEND = 1'b1
  } state_t;

  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;

endpackage

// File: rtl/bin_log2.sv
// -----------------------------------------------------------------------------
// bin_log2
// Combinational magnitude-to-level converter for one spectrum bin: the level
// is the index of the most significant set bit (0 for a zero input), clipped
// to the largest value representable in LEVEL_W bits.
//   i_data  : DATA_W-bit FFT magnitude
//   o_level : LEVEL_W-bit bar level
// -----------------------------------------------------------------------------
module bin_log2 #(
  parameter int DATA_W  = 16,
  parameter int LEVEL_W = 4
) (
  input  logic [DATA_W-1:0]  i_data,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int LMAX = (2 ** LEVEL_W) - 1;

  int w_msb;

  // Priority scan: the highest set bit is the last one to write w_msb.
  always_comb begin
    w_msb = 0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i_data[i]) begin
        w_msb = i;
      end else begin
        w_msb = w_msb;
      end
    end
    if (w_msb > LMAX) begin
      o_level = LEVEL_W'(LMAX);
    end else begin
      o_level = LEVEL_W'(w_msb);
    end
  end

endmodule

// File: rtl/peak_spectrum_renderer.sv
// -----------------------------------------------------------------------------
// peak_spectrum_renderer
// Renders an FFT magnitude spectrum as vertical green bars with optional white
// falling peak markers on a VGA raster. New spectra are held in a shadow
// buffer and only committed to the displayed levels while the frame is not
// being scanned, so a bar never changes height mid-frame.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_fft_data            : NUM_BINS x DATA_W magnitudes, bin b at [b*DATA_W +: DATA_W]
//   i_fft_done            : one-cycle valid strobe for i_fft_data
//   i_VGA_X, i_VGA_Y      : current pixel coordinate
//   i_VGA_lock            : high while the frame is being scanned
//   i_peak_en             : enable white peak markers
//   o_VGA_R/G/B           : registered pixel colour (one cycle after X/Y)
// -----------------------------------------------------------------------------
module peak_spectrum_renderer
  import renderer_pkg::*;
#(
  parameter int NUM_BINS     = 16,
  parameter int DATA_W       = 16,
  parameter int LEVEL_W      = 4,
  parameter int BAR_W        = 32,
  parameter int GAP_W        = 4,
  parameter int UNIT_H       = 30,
  parameter int SCREEN_H     = 480,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_BINS*DATA_W-1:0]   i_fft_data,
  input  logic                         i_fft_done,
  input  logic [10:0]                  i_VGA_X,
  input  logic [10:0]                  i_VGA_Y,
  input  logic                         i_VGA_lock,
  input  logic                         i_peak_en,
  output logic [7:0]                   o_VGA_R,
  output logic [7:0]                   o_VGA_G,
  output logic [7:0]                   o_VGA_B
);

  localparam int OFF_W = $clog2(BAR_W);
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int DW    = $clog2(DECAY_FRAMES + 1);
  // Signed height arithmetic wide enough for the full screen, the tallest
  // bar and any 11-bit Y, so tops above the screen stay negative.
  localparam int HW    = $clog2(SCREEN_H + (2 ** LEVEL_W) * UNIT_H + 2048) + 1;

  localparam logic signed [HW-1:0] C_SCREEN_H = HW'(SCREEN_H);
  localparam logic signed [HW-1:0] C_UNIT_H   = HW'(UNIT_H);
  localparam logic signed [HW-1:0] C_TWO      = HW'(2);

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_BINS*DATA_W-1:0] r_shadow;
  logic [LEVEL_W-1:0]    r_level [NUM_BINS];
  logic [LEVEL_W-1:0]    r_peak  [NUM_BINS];
  logic [DW-1:0]         r_decay [NUM_BINS];
  logic [LEVEL_W-1:0]    w_new_level  [NUM_BINS];
  logic [LEVEL_W-1:0]    w_level_next [NUM_BINS];
  logic                  r_origin_prev;
  logic [23:0]           r_rgb;

  logic                  w_commit;
  logic                  w_at_origin;
  logic                  w_frame_start;

  assign w_commit      = (r_state == S_PEND) && !i_VGA_lock;
  assign w_at_origin   = (i_VGA_X == 11'd0) && (i_VGA_Y == 11'd0);
  assign w_frame_start = w_at_origin && !r_origin_prev;

  // Per-bin level conversion always looks at the shadow, so a commit that
  // coincides with a new capture still uses the older spectrum.
  for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
    bin_log2 #(
      .DATA_W (DATA_W),
      .LEVEL_W(LEVEL_W)
    ) u_log2 (
      .i_data (r_shadow[g*DATA_W +: DATA_W]),
      .o_level(w_new_level[g])
    );
  end

  // Next-state logic for the shadow/commit handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (i_fft_done) begin
          w_state_next = S_PEND;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_PEND: begin
        if (w_commit && !i_fft_done) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_PEND;
        end
      end
      default: w_state_next = S_WAIT;
    endcase
  end

  // State register, shadow capture (latest strobe wins) and frame-start history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_WAIT;
      r_shadow      <= '0;
      r_origin_prev <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_origin_prev <= w_at_origin;
      if (i_fft_done) begin
        r_shadow <= i_fft_data;
      end
    end
  end

  // Level each bin will hold after this edge; peaks never decay below it.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      if (w_commit) begin
        w_level_next[b] = w_new_level[b];
      end else begin
        w_level_next[b] = r_level[b];
      end
    end
  end

  // Levels, peak hold and peak decay. A commit that raises (or equals) the
  // peak overrides any decay step in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        r_level[b] <= '0;
        r_peak[b]  <= '0;
        r_decay[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BINS; b++) begin
        r_level[b] <= w_level_next[b];
        if (w_commit && (w_new_level[b] >= r_peak[b])) begin
          r_peak[b]  <= w_new_level[b];
          r_decay[b] <= '0;
        end else if (w_frame_start) begin
          if (r_decay[b] == DW'(DECAY_FRAMES - 1)) begin
            r_decay[b] <= '0;
            if (r_peak[b] > w_level_next[b]) begin
              r_peak[b] <= r_peak[b] - 1'b1;
            end
          end else begin
            r_decay[b] <= r_decay[b] + 1'b1;
          end
        end
      end
    end
  end

  // Pixel mapping.
  logic [10:0]              w_bin;
  logic [OFF_W-1:0]         w_off;
  logic [BIN_W-1:0]         w_sel;
  logic [LEVEL_W-1:0]       w_lvl;
  logic [LEVEL_W-1:0]       w_pk;
  logic signed [HW-1:0]     w_lvl_s;
  logic signed [HW-1:0]     w_pk_s;
  logic signed [HW-1:0]     w_y_s;
  logic signed [HW-1:0]     w_bar_top;
  logic signed [HW-1:0]     w_peak_top;
  logic                     w_black_zone;
  logic [23:0]              w_rgb;

  assign w_bin      = i_VGA_X >> OFF_W;
  assign w_off      = i_VGA_X[OFF_W-1:0];
  assign w_sel      = w_bin[BIN_W-1:0];
  assign w_lvl      = r_level[w_sel];
  assign w_pk       = r_peak[w_sel];
  assign w_lvl_s    = $signed({{(HW-LEVEL_W){1'b0}}, w_lvl});
  assign w_pk_s     = $signed({{(HW-LEVEL_W){1'b0}}, w_pk});
  assign w_y_s      = $signed({{(HW-11){1'b0}}, i_VGA_Y});
  assign w_bar_top  = C_SCREEN_H - (w_lvl_s * C_UNIT_H);
  assign w_peak_top = C_SCREEN_H - (w_pk_s * C_UNIT_H);
  // Out-of-range bins are masked here, so the truncated w_sel lookup is harmless.
  assign w_black_zone = (w_bin >= 11'(NUM_BINS)) ||
                        (w_off >= OFF_W'(BAR_W - GAP_W)) ||
                        (i_VGA_Y >= 11'(SCREEN_H));

  // Colour priority: blank zones, then peak marker, then bar body.
  always_comb begin
    w_rgb = C_BLACK;
    if (w_black_zone) begin
      w_rgb = C_BLACK;
    end else if (i_peak_en && (w_pk != '0) &&
                 (w_y_s >= (w_peak_top - C_TWO)) && (w_y_s < w_peak_top)) begin
      w_rgb = C_WHITE;
    end else if (w_y_s >= w_bar_top) begin
      w_rgb = C_GREEN;
    end else begin
      w_rgb = C_BLACK;
    end
  end

  // Registered colour output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb <= 24'h000000;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign o_VGA_R = r_rgb[23:16];
  assign o_VGA_G = r_rgb[15:8];
  assign o_VGA_B = r_rgb[7:0];

endmodule

// File: tb/tb_peak_spectrum_renderer.sv
module tb_peak_spectrum_renderer;

  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] WHT = 24'hFFFFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] fft = '0;
  logic         done = 1'b0;
  logic [10:0]  vx = 11'd5;
  logic [10:0]  vy = 11'd200;
  logic         lock = 1'b0;
  logic         pen = 1'b0;
  logic [7:0]   r_o, g_o, b_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peak_spectrum_renderer dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_fft_data(fft),
    .i_fft_done(done),
    .i_VGA_X   (vx),
    .i_VGA_Y   (vy),
    .i_VGA_lock(lock),
    .i_peak_en (pen),
    .o_VGA_R   (r_o),
    .o_VGA_G   (g_o),
    .o_VGA_B   (b_o)
  );

  // Inputs change at negedge; one call passes exactly one rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a pixel for one edge and return the registered colour.
  task automatic px(input int x, input int y, output logic [23:0] c);
    vx = 11'(x);
    vy = 11'(y);
    cyc();
    c  = {r_o, g_o, b_o};
    vx = 11'd5;
    vy = 11'd200;
  endtask

  task automatic set_bin(input int b, input logic [15:0] v);
    fft[b*16 +: 16] = v;
  endtask

  // Each frame: one cycle at the origin, one cycle away from it.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vx = 11'd0; vy = 11'd0; cyc();
      vx = 11'd5; vy = 11'd200; cyc();
    end
  endtask

  task automatic test_reset();
    logic [23:0] c;
    @(negedge clk);
    rst = 1'b1;
    fft = '1;
    done = 1'b1;
    cyc(); cyc();
    total++; if ({r_o, g_o, b_o} !== BLK) begin bad++; $display("FAIL reset_rgb: got %h want %h", {r_o, g_o, b_o}, BLK); end
    done = 1'b0;
    rst = 1'b0;
    fft = '0;
    px(0, 479, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL reset_px_0_479: got %h want %h", c, BLK); end
    cyc(); cyc();
    px(5, 479, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL reset_discard: got %h want %h", c, BLK); end
  endtask

  task automatic test_commit_gating();
    logic [23:0] c;
    lock = 1'b1;
    fft = '0;
    set_bin(0, 16'h0100);
    done = 1'b1; cyc(); done = 1'b0;
    repeat (10) cyc();
    px(5, 479, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL gate_locked: got %h want %h", c, BLK); end
    lock = 1'b0;
    cyc();
    px(5, 240, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL gate_top240: got %h want %h", c, GRN); end
    px(5, 239, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL gate_239: got %h want %h", c, BLK); end
    px(5, 200, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL gate_200: got %h want %h", c, BLK); end
    px(5, 479, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL gate_479: got %h want %h", c, GRN); end
  endtask

  task automatic test_latest_wins();
    logic [23:0] c;
    lock = 1'b1;
    fft = '0;
    set_bin(3, 16'h0010);
    done = 1'b1; cyc();
    set_bin(3, 16'hFFFF);
    cyc(); done = 1'b0; cyc();
    px(100, 479, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL latest_locked: got %h want %h", c, BLK); end
    lock = 1'b0;
    cyc();
    px(100, 30, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL latest_top30: got %h want %h", c, GRN); end
    px(100, 29, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL latest_29: got %h want %h", c, BLK); end
    px(5, 479, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL latest_bin0_cleared: got %h want %h", c, BLK); end
  endtask

  task automatic test_peak_decay();
    logic [23:0] c;
    fft = '0;
    set_bin(1, 16'h8000);
    done = 1'b1; cyc(); done = 1'b0; cyc();
    set_bin(1, 16'h0004);
    done = 1'b1; cyc(); done = 1'b0; cyc();
    pen = 1'b1;
    // peak 15 -> marker rows 28..29; level 2 -> bar from row 420
    px(40, 29, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak15_29: got %h want %h", c, WHT); end
    px(40, 28, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak15_28: got %h want %h", c, WHT); end
    px(40, 27, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL peak15_27: got %h want %h", c, BLK); end
    px(40, 30, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL peak15_30: got %h want %h", c, BLK); end
    px(40, 420, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL level2_420: got %h want %h", c, GRN); end
    px(40, 419, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL level2_419: got %h want %h", c, BLK); end
    frames(4);
    px(40, 59, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak14_59: got %h want %h", c, WHT); end
    px(40, 29, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL peak14_old29: got %h want %h", c, BLK); end
    frames(48);
    px(40, 418, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak2_418: got %h want %h", c, WHT); end
    px(40, 419, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak2_419: got %h want %h", c, WHT); end
    px(40, 417, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL peak2_417: got %h want %h", c, BLK); end
    px(40, 420, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL peak2_420: got %h want %h", c, GRN); end
    frames(8);
    px(40, 418, c);
    total++; if (c !== WHT) begin bad++; $display("FAIL peak_floor: got %h want %h", c, WHT); end
    pen = 1'b0;
    px(40, 418, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL peak_disabled: got %h want %h", c, BLK); end
  endtask

  task automatic test_boundaries();
    logic [23:0] c;
    fft = '0;
    set_bin(0, 16'hFFFF);
    set_bin(15, 16'hFFFF);
    done = 1'b1; cyc(); done = 1'b0; cyc();
    px(27, 470, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL edge_x27: got %h want %h", c, GRN); end
    for (int x = 28; x < 32; x++) begin
      px(x, 470, c);
      total++; if (c !== BLK) begin bad++; $display("FAIL gap_x%0d: got %h want %h", x, c, BLK); end
    end
    px(507, 470, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL edge_x507: got %h want %h", c, GRN); end
    px(511, 470, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL gap_x511: got %h want %h", c, BLK); end
    px(512, 470, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL bin16_x512: got %h want %h", c, BLK); end
    px(5, 480, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL y480: got %h want %h", c, BLK); end
    px(5, 479, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL y479: got %h want %h", c, GRN); end
  endtask

  task automatic test_coincidence();
    logic [23:0] c;
    lock = 1'b1;
    fft = '0;
    set_bin(4, 16'h0002);
    done = 1'b1; cyc();
    // unlock and strobe together: commit 0x0002, capture 0x0400
    lock = 1'b0;
    set_bin(4, 16'h0400);
    cyc();
    done = 1'b0;
    lock = 1'b1;
    px(130, 450, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL coin_old_450: got %h want %h", c, GRN); end
    px(130, 449, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL coin_old_449: got %h want %h", c, BLK); end
    lock = 1'b0;
    cyc();
    px(130, 180, c);
    total++; if (c !== GRN) begin bad++; $display("FAIL coin_new_180: got %h want %h", c, GRN); end
    px(130, 179, c);
    total++; if (c !== BLK) begin bad++; $display("FAIL coin_new_179: got %h want %h", c, BLK); end
  endtask

  initial begin
    test_reset();
    test_commit_gating();
    test_latest_wins();
    test_peak_decay();
    test_boundaries();
    test_coincidence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
